// File: rtl/load_counter_pkg.sv
// Shared types and sizing for the loadable up-counter.
// The counter width defaults to CNT_W; cnt_t is the matching count type.
package load_counter_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage : load_counter_pkg

// File: rtl/load_counter.sv
// Loadable free-running up-counter: each edge either loads data_in or adds one.
// Asynchronous active-high clear; q comes straight from the register.
module load_counter
  import load_counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // inc is kept only for interface compatibility; counting never depends on it.
  logic unused_inc;
  assign unused_inc = inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= data_in;
    end else begin
      q <= q + WIDTH'(1);
    end
  end

endmodule : load_counter

// File: tb/tb_load_counter.sv
// Bench for load_counter: directed literal checks plus a randomized run
// compared every falling edge against a behavioural model.
module tb_load_counter;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       ld;
  logic       inc;
  logic [7:0] q;

  int checks;
  int errors;

  logic [7:0] model_q;

  load_counter #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .ld      (ld),
    .inc     (inc),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clear while rst is high, otherwise load or advance by one (mod 256).
  always @(posedge clk or posedge rst) begin
    if (rst) model_q <= 8'h00;
    else if (ld) model_q <= data_in;
    else model_q <= 8'((int'(model_q) + 1) % 256);
  end

  always @(negedge clk) begin
    check("model", q, model_q);
  end

  // Drive inputs just after a falling edge, then let exactly one rising edge pass.
  task automatic cyc(input logic l, input logic i, input logic [7:0] d);
    ld      = l;
    inc     = i;
    data_in = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic       rl;
    logic       ri;
    logic [7:0] rd;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    ld      = 1'b0;
    inc     = 1'b0;
    data_in = 8'h00;

    #2;
    check("reset_async", q, 8'h00);
    @(negedge clk); #1;
    check("reset_hold", q, 8'h00);
    rst = 1'b0;

    // Mid-cycle asynchronous clear from a loaded value
    cyc(1'b1, 1'b0, 8'h37);
    check("load_37", q, 8'h37);
    ld = 1'b1; data_in = 8'hAA;
    #1;
    rst = 1'b1;
    #1;
    check("rst_midcycle", q, 8'h00);
    @(negedge clk); #1;
    check("rst_held_1", q, 8'h00);
    @(negedge clk); #1;
    check("rst_held_2", q, 8'h00);
    rst = 1'b0;

    // Load then count
    cyc(1'b1, 1'b0, 8'h5A);
    check("load_5a", q, 8'h5A);
    cyc(1'b0, 1'b0, 8'h00);
    check("count_5b", q, 8'h5B);
    cyc(1'b0, 1'b0, 8'h11);
    check("count_5c", q, 8'h5C);
    cyc(1'b0, 1'b0, 8'h22);
    check("count_5d", q, 8'h5D);

    // Load beats inc
    cyc(1'b1, 1'b0, 8'h10);
    check("load_10", q, 8'h10);
    cyc(1'b1, 1'b1, 8'hC3);
    check("load_priority", q, 8'hC3);

    // Counting does not depend on inc
    cyc(1'b1, 1'b0, 8'h20);
    repeat (4) cyc(1'b0, 1'b0, 8'($urandom));
    check("count_no_inc", q, 8'h24);
    cyc(1'b1, 1'b1, 8'h20);
    repeat (4) cyc(1'b0, 1'b1, 8'($urandom));
    check("count_with_inc", q, 8'h24);

    // Wrap-around
    cyc(1'b1, 1'b0, 8'hFE);
    check("load_fe", q, 8'hFE);
    cyc(1'b0, 1'b0, 8'h00);
    check("wrap_ff", q, 8'hFF);
    cyc(1'b0, 1'b1, 8'h00);
    check("wrap_00", q, 8'h00);

    // Between-edge input changes must not disturb q
    cyc(1'b1, 1'b0, 8'h80);
    ld = 1'b1; data_in = 8'h01;
    #2;
    check("no_effect_between_edges", q, 8'h80);
    ld = 1'b0;
    @(negedge clk); #1;
    check("after_glitch", q, 8'h81);

    // Randomized regression, each setting held for two edges
    for (int n = 0; n < 50; n++) begin
      rl = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      repeat (2) cyc(rl, ri, rd);
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_load_counter
